// File: rtl/tree_adder_pkg.sv
// Shared constants and width helpers for the pipelined adder tree.
package tree_adder_pkg;

  localparam int ACC_GUARD_BITS = 8;

  // Width of every partial sum produced by tree level `level`.
  function automatic int level_width(input int data_width, input int level);
    return data_width + level;
  endfunction

endpackage

// File: rtl/tree_adder_level.sv
// One registered level of the adder tree: PAIRS adjacent pairs of IN_W-bit
// values become PAIRS sums, each one bit wider, all advancing together.
module tree_adder_level
  import tree_adder_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int PAIRS  = 1,
  parameter int SIGNED = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  advance,
  input  logic                                  in_valid,
  input  logic [2*PAIRS*IN_W-1:0]               in_data,
  output logic                                  out_valid,
  output logic [PAIRS*level_width(IN_W,1)-1:0]  out_data
);

  localparam int OUT_W = level_width(IN_W, 1);

  logic [PAIRS*OUT_W-1:0] sum_next;
  logic [PAIRS*OUT_W-1:0] data_reg;
  logic                   valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < PAIRS; gi++) begin : g_pair
      logic [IN_W-1:0] op_a;
      logic [IN_W-1:0] op_b;
      logic            ext_a;
      logic            ext_b;
      assign op_a  = in_data[(2*gi)*IN_W +: IN_W];
      assign op_b  = in_data[(2*gi+1)*IN_W +: IN_W];
      assign ext_a = (SIGNED != 0) ? op_a[IN_W-1] : 1'b0;
      assign ext_b = (SIGNED != 0) ? op_b[IN_W-1] : 1'b0;
      assign sum_next[gi*OUT_W +: OUT_W] = {ext_a, op_a} + {ext_b, op_b};
    end
  endgenerate

  // Data is only loaded for real beats so an idle pipe keeps its last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (advance) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= sum_next;
      end
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/tree_adder_pipe.sv
// Pipelined balanced adder tree over 2**N operands with valid/ready flow control.
// Optional running accumulator enabled by macro TREE_ADDER_PIPE_ACC_EN.
module tree_adder_pipe
  import tree_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int N          = 3,
  parameter int SIGNED     = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*(2**N)-1:0]      in_data,
`ifdef TREE_ADDER_PIPE_ACC_EN
  input  logic                              in_last,
  output logic                              out_last,
  output logic [DATA_WIDTH+N+ACC_GUARD_BITS-1:0] out_acc,
`endif
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH+N-1:0]           out_sum
);

  localparam int SUM_W = level_width(DATA_WIDTH, N);

  // The whole tree stalls only when a finished result is waiting on the sink.
  assign in_ready = out_ready | ~out_valid;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lvl
      localparam int IN_W  = level_width(DATA_WIDTH, gi);
      localparam int PAIRS = 2 ** (N - 1 - gi);

      logic [2*PAIRS*IN_W-1:0]      lvl_in;
      logic                         lvl_in_valid;
      logic [PAIRS*(IN_W+1)-1:0]    lvl_out;
      logic                         lvl_out_valid;

      if (gi == 0) begin : g_first
        assign lvl_in       = in_data;
        assign lvl_in_valid = in_valid;
      end else begin : g_next
        assign lvl_in       = g_lvl[gi-1].lvl_out;
        assign lvl_in_valid = g_lvl[gi-1].lvl_out_valid;
      end

      tree_adder_level #(
        .IN_W   (IN_W),
        .PAIRS  (PAIRS),
        .SIGNED (SIGNED)
      ) u_level (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (in_ready),
        .in_valid  (lvl_in_valid),
        .in_data   (lvl_in),
        .out_valid (lvl_out_valid),
        .out_data  (lvl_out)
      );
    end
  endgenerate

  assign out_valid = g_lvl[N-1].lvl_out_valid;
  assign out_sum   = g_lvl[N-1].lvl_out[SUM_W-1:0];

`ifdef TREE_ADDER_PIPE_ACC_EN
  localparam int ACC_W = SUM_W + ACC_GUARD_BITS;

  logic [N-1:0]     last_pipe_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] sum_ext;

  // in_last rides alongside the data, one flag per level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pipe_reg <= '0;
    end else if (in_ready) begin
      last_pipe_reg[0] <= in_last;
      for (int i = 1; i < N; i++) begin
        last_pipe_reg[i] <= last_pipe_reg[i-1];
      end
    end
  end

  assign out_last = last_pipe_reg[N-1];
  assign sum_ext  = (SIGNED != 0) ? {{ACC_GUARD_BITS{out_sum[SUM_W-1]}}, out_sum}
                                  : {{ACC_GUARD_BITS{1'b0}}, out_sum};
  assign out_acc  = acc_reg + sum_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (out_valid && out_ready) begin
      acc_reg <= out_last ? '0 : out_acc;
    end
  end
`endif

endmodule

// File: tb/tb_tree_adder_pipe.sv
// Directed and randomised checks of tree_adder_pipe (unsigned and signed builds).
module tb_tree_adder_pipe;

  logic        tb_clk = 1'b0;
  logic        rst_n  = 1'b1;

  logic        u_in_valid, u_in_ready, u_out_valid, u_out_ready, u_in_last;
  logic [31:0] u_in_data;
  logic [6:0]  u_out_sum;
  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_in_last;
  logic [31:0] s_in_data;
  logic [6:0]  s_out_sum;
`ifdef TREE_ADDER_PIPE_ACC_EN
  logic        u_out_last, s_out_last;
  logic [14:0] u_out_acc, s_out_acc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 tb_clk = ~tb_clk;

  tree_adder_pipe #(.DATA_WIDTH(4), .N(3), .SIGNED(0)) dut_u (
    .clk(tb_clk), .rst_n(rst_n),
    .in_valid(u_in_valid), .in_ready(u_in_ready), .in_data(u_in_data),
`ifdef TREE_ADDER_PIPE_ACC_EN
    .in_last(u_in_last), .out_last(u_out_last), .out_acc(u_out_acc),
`endif
    .out_valid(u_out_valid), .out_ready(u_out_ready), .out_sum(u_out_sum)
  );

  tree_adder_pipe #(.DATA_WIDTH(4), .N(3), .SIGNED(1)) dut_s (
    .clk(tb_clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
`ifdef TREE_ADDER_PIPE_ACC_EN
    .in_last(s_in_last), .out_last(s_out_last), .out_acc(s_out_acc),
`endif
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_sum(s_out_sum)
  );

  typedef struct {
    string       name;
    bit          sgn;
    logic [31:0] data;
    logic [6:0]  exp_sum;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  function automatic logic get_valid(input bit sgn);
    return sgn ? s_out_valid : u_out_valid;
  endfunction

  function automatic logic [6:0] get_sum(input bit sgn);
    return sgn ? s_out_sum : u_out_sum;
  endfunction

  function automatic logic [6:0] sum_nib(input logic [31:0] d);
    logic [6:0] s = '0;
    for (int k = 0; k < 8; k++) s += 7'(d[4*k +: 4]);
    return s;
  endfunction

  // One beat through an otherwise idle pipe; result must appear exactly 3 cycles on, for 1 cycle.
  task automatic apply_vec(input vec_t v);
    if (v.sgn) begin s_in_valid = 1'b1; s_in_data = v.data; end
    else       begin u_in_valid = 1'b1; u_in_data = v.data; end
    step();
    s_in_valid = 1'b0;
    u_in_valid = 1'b0;
    check({v.name, "_early1"}, 32'(get_valid(v.sgn)), 32'd0);
    step();
    check({v.name, "_early2"}, 32'(get_valid(v.sgn)), 32'd0);
    step();
    check({v.name, "_valid"}, 32'(get_valid(v.sgn)), 32'd1);
    check({v.name, "_sum"}, 32'(get_sum(v.sgn)), 32'(v.exp_sum));
    step();
    check({v.name, "_one_cycle"}, 32'(get_valid(v.sgn)), 32'd0);
  endtask

  // Streams nbeats through dut_u; rnd=0 is the 1..10 ramp with a 5-cycle sink stall.
  task automatic run_stream(input bit rnd, input int nbeats, input int limit);
    logic [6:0] q[$];
    logic [6:0] held = '0;
    logic [6:0] exp;
    bit         stalled = 1'b0;
    int         sent = 0, got = 0, cyc = 0, stall_cycles = 0;
    string      tag;
    tag = rnd ? "rand" : "ramp";
    while (got < nbeats && cyc < limit) begin
      step();
      cyc++;
      if (stalled) begin
        check({tag, "_hold_valid"}, 32'(u_out_valid), 32'd1);
        check({tag, "_hold_sum"}, 32'(u_out_sum), 32'(held));
      end
      if (rnd) begin
        u_out_ready = ($urandom_range(0, 3) != 0);
        u_in_valid  = (sent < nbeats) && ($urandom_range(0, 1) == 1);
        u_in_data   = $urandom();
      end else begin
        u_out_ready = !(cyc >= 6 && cyc <= 10);
        u_in_valid  = (sent < nbeats);
        u_in_data   = {8{4'(sent + 1)}};
      end
      #1;
      check({tag, "_in_ready"}, 32'(u_in_ready), 32'(!(u_out_valid && !u_out_ready)));
      if (!u_in_ready) stall_cycles++;
      if (u_out_valid && u_out_ready) begin
        if (q.size() == 0) begin
          check({tag, "_spurious"}, 32'(u_out_sum), 32'hFFFF_FFFF);
        end else begin
          exp = q.pop_front();
          check($sformatf("%s_sum%0d", tag, got), 32'(u_out_sum), 32'(exp));
        end
        got++;
      end
      stalled = u_out_valid && !u_out_ready;
      held    = u_out_sum;
      if (u_in_valid && u_in_ready) begin
        q.push_back(rnd ? sum_nib(u_in_data) : 7'((sent + 1) * 8));
        sent++;
      end
    end
    u_in_valid  = 1'b0;
    u_out_ready = 1'b1;
    check({tag, "_count"}, 32'(got), 32'(nbeats));
    if (!rnd) check("ramp_stall_cycles", 32'(stall_cycles), 32'd5);
    repeat (4) step();
    check({tag, "_drained"}, 32'(u_out_valid), 32'd0);
  endtask

  initial begin
    vecs[0] = '{"u_all15",   1'b0, 32'hFFFF_FFFF, 7'd120};
    vecs[1] = '{"u_zero",    1'b0, 32'h0000_0000, 7'd0};
    vecs[2] = '{"u_ramp07",  1'b0, 32'h7654_3210, 7'd28};
    vecs[3] = '{"u_top15",   1'b0, 32'hF000_0000, 7'd15};
    vecs[4] = '{"s_allm8",   1'b1, 32'h8888_8888, 7'h40};
    vecs[5] = '{"s_alt7m8",  1'b1, 32'h8787_8787, 7'h7C};
    vecs[6] = '{"s_all7",    1'b1, 32'h7777_7777, 7'd56};
    vecs[7] = '{"s_allm1",   1'b1, 32'hFFFF_FFFF, 7'h78};

    u_in_valid = 1'b1; u_in_data = 32'h1111_1111; u_out_ready = 1'b1; u_in_last = 1'b0;
    s_in_valid = 1'b0; s_in_data = '0;            s_out_ready = 1'b1; s_in_last = 1'b0;

    // Reset asserted while a beat is offered: nothing may be accepted.
    #1 rst_n = 1'b0;
    #1;
    check("rst_u_valid", 32'(u_out_valid), 32'd0);
    check("rst_u_sum",   32'(u_out_sum),   32'd0);
    check("rst_u_ready", 32'(u_in_ready),  32'd1);
    check("rst_s_valid", 32'(s_out_valid), 32'd0);
    check("rst_s_sum",   32'(s_out_sum),   32'd0);
    repeat (3) begin
      step();
      check("rst_hold_valid", 32'(u_out_valid), 32'd0);
    end
    rst_n = 1'b1;
    step();
    u_in_valid = 1'b0;
    step();
    check("first_beat_early", 32'(u_out_valid), 32'd0);
    step();
    check("first_beat_valid", 32'(u_out_valid), 32'd1);
    check("first_beat_sum",   32'(u_out_sum),   32'd8);
    step();
    check("first_beat_gone",  32'(u_out_valid), 32'd0);
    step();
    check("idle_sum_stable",  32'(u_out_sum),   32'd8);

    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    run_stream(1'b0, 10, 200);

    // Reset pulse between edges with one result stalled at the output and one behind it.
    u_out_ready = 1'b0;
    u_in_valid  = 1'b1;
    u_in_data   = 32'h1111_1111;
    step();
    u_in_data   = 32'h2222_2222;
    step();
    u_in_valid  = 1'b0;
    step();
    check("midrst_pre_valid", 32'(u_out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid_now", 32'(u_out_valid), 32'd0);
    check("midrst_sum_now",   32'(u_out_sum),   32'd0);
    #1 rst_n = 1'b1;
    u_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("midrst_quiet%0d", i), 32'(u_out_valid), 32'd0);
    end

`ifdef TREE_ADDER_PIPE_ACC_EN
    begin
      logic [31:0] d[4]  = '{32'h0000_0055, 32'h0000_5555, 32'h0055_5555, 32'h0000_0005};
      logic        l[4]  = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [6:0]  es[4] = '{7'd10, 7'd20, 7'd30, 7'd5};
      logic [14:0] ea[4] = '{15'd10, 15'd30, 15'd60, 15'd5};
      rst_n = 1'b0;
      #1 rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
        if (i < 4) begin u_in_valid = 1'b1; u_in_data = d[i]; u_in_last = l[i]; end
        else       begin u_in_valid = 1'b0; u_in_last = 1'b0; end
        step();
        if (i >= 2) begin
          check($sformatf("acc_valid%0d", i - 2), 32'(u_out_valid), 32'd1);
          check($sformatf("acc_sum%0d",   i - 2), 32'(u_out_sum),   32'(es[i-2]));
          check($sformatf("acc_acc%0d",   i - 2), 32'(u_out_acc),   32'(ea[i-2]));
          check($sformatf("acc_last%0d",  i - 2), 32'(u_out_last),  32'(l[i-2]));
        end
      end
      step();
    end
`endif

    run_stream(1'b1, 1000, 8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
